// File: rtl/fsm1_pkg.sv
// Shared types and defaults for the fsm1 handshake blocks.
// Target wait-state encoding lives here so initiator benches can decode it.
package fsm1_pkg;

    localparam int TGT_WW = 4;

    // T_XXX is the one unused encoding; the target FSM recovers from it to T_IDLE.
    typedef enum logic [1:0] {
        T_IDLE = 2'b00,
        T_WAIT = 2'b01,
        T_DATA = 2'b10,
        T_XXX  = 2'b11
    } tstate_e;

endpackage

// File: rtl/fsm1_tgt_mem.sv
// Backing store for the fsm1 target: 2**AW x DW registers, one write port
// and one asynchronous read port. Contents are not reset.
module fsm1_tgt_mem #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Async read: a write on the same edge is seen only after that edge.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsm1_target.sv
// Responder end of the fsm1 rd/ws/ds read handshake with programmable wait states.
// Define FSM1_TGT_WCFG_EN to add a run-time wait_cfg input that replaces WAIT_CYC.
module fsm1_target
    import fsm1_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int WAIT_CYC = 3,
    parameter int WW       = TGT_WW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
`ifdef FSM1_TGT_WCFG_EN
    input  logic [WW-1:0] wait_cfg,
`endif
    output logic          ws,
    output logic [DW-1:0] rdata,
    output logic          abt
);

    tstate_e       state_q;
    logic [WW-1:0] cnt_q;
    logic [DW-1:0] rdata_q;
    logic          abt_q;
    logic [DW-1:0] mem_rdata;
    logic [WW-1:0] load_cnt;

`ifdef FSM1_TGT_WCFG_EN
    assign load_cnt = wait_cfg;
`else
    assign load_cnt = WW'(WAIT_CYC);
`endif

    fsm1_tgt_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    // The wait count is latched at acceptance, so later wait_cfg changes
    // cannot stretch or shorten a read already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            abt_q   <= 1'b0;
        end else begin
            abt_q <= 1'b0;
            case (state_q)
                T_IDLE: begin
                    if (rd) begin
                        rdata_q <= mem_rdata;
                        cnt_q   <= load_cnt;
                        state_q <= (load_cnt != '0) ? T_WAIT : T_DATA;
                    end
                end
                T_WAIT: begin
                    if (rd) begin
                        cnt_q <= cnt_q - WW'(1);
                        if (cnt_q == WW'(1)) state_q <= T_DATA;
                    end else begin
                        state_q <= T_IDLE;
                        abt_q   <= 1'b1;
                    end
                end
                T_DATA: begin
                    if (!rd) state_q <= T_IDLE;
                end
                default: begin
                    state_q <= T_IDLE;
                    rdata_q <= 'x;
                    abt_q   <= 1'bx;
                end
            endcase
        end
    end

    assign ws    = (state_q == T_WAIT);
    assign rdata = rdata_q;
    assign abt   = abt_q;

endmodule

// File: tb/tb_fsm1_target.sv
// Bench for fsm1_target: three instances (WAIT_CYC 3, 0, 5) on shared stimulus,
// checked every cycle against a transaction-level model plus directed checks.
module tb_fsm1_target;

    logic       clk;
    logic       rst_n;
    logic       rd;
    logic [3:0] addr;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] wait_cfg;
    logic       ws_o    [3];
    logic [7:0] rdata_o [3];
    logic       abt_o   [3];

    int nchk = 0;
    int nerr = 0;

    fsm1_target #(.DW(8), .AW(4), .WAIT_CYC(3), .WW(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd(rd), .addr(addr), .we(we), .waddr(waddr), .wdata(wdata),
`ifdef FSM1_TGT_WCFG_EN
        .wait_cfg(wait_cfg),
`endif
        .ws(ws_o[0]), .rdata(rdata_o[0]), .abt(abt_o[0]));

    fsm1_target #(.DW(8), .AW(4), .WAIT_CYC(0), .WW(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rd(rd), .addr(addr), .we(we), .waddr(waddr), .wdata(wdata),
`ifdef FSM1_TGT_WCFG_EN
        .wait_cfg(wait_cfg),
`endif
        .ws(ws_o[1]), .rdata(rdata_o[1]), .abt(abt_o[1]));

    fsm1_target #(.DW(8), .AW(4), .WAIT_CYC(5), .WW(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .rd(rd), .addr(addr), .we(we), .waddr(waddr), .wdata(wdata),
`ifdef FSM1_TGT_WCFG_EN
        .wait_cfg(wait_cfg),
`endif
        .ws(ws_o[2]), .rdata(rdata_o[2]), .abt(abt_o[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: per instance, a transaction is "open" from acceptance until rd drops;
    // el counts rd-high edges since acceptance, and ws is expected while el < wait.
    localparam int WC [3] = '{3, 0, 5};
    bit         m_busy [3];
    int         m_el   [3];
    int         m_wt   [3];
    logic [7:0] m_dat  [3];
    bit         m_abt  [3];
    logic [7:0] m_mem  [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0;
            m_el[d]   = 0;
            m_wt[d]   = 0;
            m_dat[d]  = 8'h00;
            m_abt[d]  = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        for (int d = 0; d < 3; d++) begin
            m_abt[d] = 1'b0;
            if (!m_busy[d]) begin
                if (rd) begin
                    m_busy[d] = 1'b1;
                    m_el[d]   = 0;
`ifdef FSM1_TGT_WCFG_EN
                    m_wt[d]   = int'(wait_cfg);
`else
                    m_wt[d]   = WC[d];
`endif
                    m_dat[d]  = m_mem[addr];
                end
            end else if (rd) begin
                m_el[d]++;
            end else begin
                m_abt[d]  = (m_el[d] < m_wt[d]);
                m_busy[d] = 1'b0;
            end
        end
        if (we) m_mem[waddr] = wdata;
    endfunction

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ws[%0d]", d), 32'(ws_o[d]), 32'(m_busy[d] && (m_el[d] < m_wt[d])));
            chk($sformatf("rdata[%0d]", d), 32'(rdata_o[d]), 32'(m_dat[d]));
            chk($sformatf("abt[%0d]", d), 32'(abt_o[d]), 32'(m_abt[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ws[%0d]", d), 32'(ws_o[d]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", d), 32'(rdata_o[d]), 32'd0);
            chk($sformatf("rst_abt[%0d]", d), 32'(abt_o[d]), 32'd0);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
        wait_cfg = 4'd3;
        model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("por_ws[%0d]", d), 32'(ws_o[d]), 32'd0);
            chk($sformatf("por_rdata[%0d]", d), 32'(rdata_o[d]), 32'd0);
            chk($sformatf("por_abt[%0d]", d), 32'(abt_o[d]), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        step(); step();

        // Preload every location so no read ever returns uninitialised data.
        we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            waddr = 4'(i);
            wdata = 8'(i * 17 + 1);
            step();
        end
        waddr = 4'd3; wdata = 8'hA5; step();
        waddr = 4'd5; wdata = 8'h3C; step();
        waddr = 4'd2; wdata = 8'h11; step();
        we = 1'b0;

`ifndef FSM1_TGT_WCFG_EN
        // Zero-wait and 3-wait read of addr 3 side by side.
        rd = 1'b1; addr = 4'd3;
        step();
        chk("w0_ws_c1", 32'(ws_o[1]), 32'd0);
        chk("w0_rdata_c1", 32'(rdata_o[1]), 32'hA5);
        chk("w3_ws_c1", 32'(ws_o[0]), 32'd1);
        step(); step();
        chk("w3_ws_c3", 32'(ws_o[0]), 32'd1);
        step();
        chk("w3_ws_c4", 32'(ws_o[0]), 32'd0);
        chk("w3_rdata_c4", 32'(rdata_o[0]), 32'hA5);
        rd = 1'b0; step(); step();

        // Abort during the wait of the WAIT_CYC=5 instance.
        rd = 1'b1; addr = 4'd5;
        step(); step();
        rd = 1'b0;
        step();
        chk("abt5_ws_c3", 32'(ws_o[2]), 32'd0);
        chk("abt5_pulse_c3", 32'(abt_o[2]), 32'd1);
        chk("abt5_rdata_c3", 32'(rdata_o[2]), 32'h3C);
        step();
        chk("abt5_clear_c4", 32'(abt_o[2]), 32'd0);

        // Write to the in-flight address keeps the captured value.
        rd = 1'b1; addr = 4'd2;
        step(); step();
        we = 1'b1; waddr = 4'd2; wdata = 8'h22;
        step();
        we = 1'b0;
        step(); step();
        chk("wdw_ws", 32'(ws_o[0]), 32'd0);
        chk("wdw_rdata_old", 32'(rdata_o[0]), 32'h11);
        rd = 1'b0; step();
        rd = 1'b1; step();
        chk("wdw_rdata_new", 32'(rdata_o[0]), 32'h22);
        rd = 1'b0; step();

        // Accept and write on the same edge, same address: old contents win.
        rd = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 8'h33;
        step();
        we = 1'b0;
        chk("rbw_rdata", 32'(rdata_o[1]), 32'h22);
        step();
        mid_reset();
        rd = 1'b0; step(); step();
`else
        // Run-time wait count latched at acceptance.
        wait_cfg = 4'd2; rd = 1'b1; addr = 4'd5;
        step();
        wait_cfg = 4'd7;
        chk("wcfg_ws_c1", 32'(ws_o[0]), 32'd1);
        step();
        chk("wcfg_ws_c2", 32'(ws_o[0]), 32'd1);
        step();
        chk("wcfg_ws_c3", 32'(ws_o[0]), 32'd0);
        chk("wcfg_rdata", 32'(rdata_o[0]), 32'h3C);
        rd = 1'b0; step();
        rd = 1'b1; step();
        chk("wcfg7_ws_c1", 32'(ws_o[0]), 32'd1);
        mid_reset();
        rd = 1'b0; step(); step();
`endif

        // Randomised traffic: sticky rd, random preload writes and wait_cfg.
        for (int n = 0; n < 600; n++) begin
            if (rd) rd = ($urandom_range(7) != 0);
            else    rd = ($urandom_range(2) == 0);
            addr  = 4'($urandom_range(15));
            we    = ($urandom_range(3) == 0);
            waddr = 4'($urandom_range(15));
            wdata = 8'($urandom_range(255));
`ifdef FSM1_TGT_WCFG_EN
            wait_cfg = 4'($urandom_range(7));
`endif
            step();
            if (n == 300) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
